// File: rtl/sdram_fifo_cmd_exec_pkg.sv
// Shared definitions for the SDRAM command executor: command word layout,
// AHB HSIZE codes and the executor state encoding.
package sdram_fifo_cmd_exec_pkg;

    localparam int CMD_FIFO_DATA_WIDTH = 36;

    // Command word layout: {write, size[2:0], addr[31:0]}
    localparam int CMD_WRITE_BIT = 35;
    localparam int CMD_SIZE_MSB  = 34;
    localparam int CMD_SIZE_LSB  = 32;
    localparam int CMD_ADDR_MSB  = 31;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WDATA_WAIT = 3'd1,
        ST_REQ        = 3'd2,
        ST_RD_WAIT    = 3'd3,
        ST_RD_PUSH    = 3'd4
    } state_t;

endpackage

// File: rtl/sdram_fifo_cmd_exec_be_decode.sv
// Byte-enable decoder: turns an AHB transfer size and the low address bits
// into the active-high lane mask used by the SDRAM core.
module sdram_be_decode
    import sdram_fifo_cmd_exec_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] be_o
);

    // Anything wider than a halfword covers the whole 32-bit word.
    always_comb begin
        be_o = 4'b1111;
        if (size_i == HSIZE_BYTE) begin
            be_o = 4'b0001 << addr_lo_i;
        end else if (size_i == HSIZE_HALF) begin
            be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end
    end

endmodule

// File: rtl/sdram_fifo_cmd_exec.sv
// Executes commands from a show-ahead command FIFO against the SDRAM core,
// one request at a time, pulling write data and pushing read data via FIFOs.
module sdram_fifo_cmd_exec
    import sdram_fifo_cmd_exec_pkg::*;
#(
    parameter int ADDR_WIDTH = 26
) (
    input  logic                           CLK,
    input  logic                           RST,
    output logic                           CFIFO_REN,
    input  logic [CMD_FIFO_DATA_WIDTH-1:0] CFIFO_RDATA,
    input  logic                           CFIFO_REMPTY,
    output logic                           WFIFO_REN,
    input  logic [31:0]                    WFIFO_RDATA,
    input  logic                           WFIFO_REMPTY,
    output logic                           RFIFO_WEN,
    output logic [31:0]                    RFIFO_WDATA,
    input  logic                           RFIFO_WFULL,
    output logic                           MEM_REQ,
    output logic                           MEM_WE,
    output logic [ADDR_WIDTH-3:0]          MEM_ADDR,
    output logic [3:0]                     MEM_BE,
    output logic [31:0]                    MEM_WDATA,
    input  logic                           MEM_ACK,
    input  logic                           MEM_RVALID,
    input  logic [31:0]                    MEM_RDATA
);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [3:0]            be_dec;
    logic                  cfifo_pop, wfifo_pop, rfifo_push;
    logic                  cmd_addr_unused;

    sdram_be_decode u_be_decode (
        .size_i    (CFIFO_RDATA[CMD_SIZE_MSB:CMD_SIZE_LSB]),
        .addr_lo_i (CFIFO_RDATA[1:0]),
        .be_o      (be_dec)
    );

    // Address bits above the SDRAM range are deliberately dropped.
    if (ADDR_WIDTH < 32) begin : g_addr_trunc
        assign cmd_addr_unused = ^CFIFO_RDATA[CMD_ADDR_MSB:ADDR_WIDTH];
    end else begin : g_addr_full
        assign cmd_addr_unused = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cfifo_pop  = 1'b0;
        wfifo_pop  = 1'b0;
        rfifo_push = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!CFIFO_REMPTY) begin
                    cfifo_pop = 1'b1;
                    we_d      = CFIFO_RDATA[CMD_WRITE_BIT];
                    addr_d    = CFIFO_RDATA[ADDR_WIDTH-1:2];
                    be_d      = be_dec;
                    state_d   = CFIFO_RDATA[CMD_WRITE_BIT] ? ST_WDATA_WAIT : ST_REQ;
                end
            end
            ST_WDATA_WAIT: begin
                if (!WFIFO_REMPTY) begin
                    wfifo_pop = 1'b1;
                    wdata_d   = WFIFO_RDATA;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // A read may complete in the same cycle it is accepted.
                if (MEM_ACK) begin
                    if (we_q) begin
                        state_d = ST_IDLE;
                    end else if (MEM_RVALID) begin
                        rdata_d = MEM_RDATA;
                        state_d = ST_RD_PUSH;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (MEM_RVALID) begin
                    rdata_d = MEM_RDATA;
                    state_d = ST_RD_PUSH;
                end
            end
            ST_RD_PUSH: begin
                rfifo_push = !RFIFO_WFULL;
                if (!RFIFO_WFULL) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // FIFO strobes are held off while reset is applied so nothing is lost.
    assign CFIFO_REN   = cfifo_pop & ~RST;
    assign WFIFO_REN   = wfifo_pop & ~RST;
    assign RFIFO_WEN   = rfifo_push & ~RST;
    assign RFIFO_WDATA = rdata_q;
    assign MEM_REQ     = (state_q == ST_REQ);
    assign MEM_WE      = we_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_BE      = be_q;
    assign MEM_WDATA   = wdata_q;

endmodule

// File: tb/tb_sdram_fifo_cmd_exec.sv
// Scoreboard bench for sdram_fifo_cmd_exec: FIFO and SDRAM-core models drive
// the DUT while a monitor compares every memory request and read-data push.
module tb_sdram_fifo_cmd_exec;

    localparam int AW = 26;

    typedef struct packed {
        logic          we;
        logic [AW-3:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } memTxn_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          CFIFO_REN;
    logic [35:0]   CFIFO_RDATA;
    logic          CFIFO_REMPTY;
    logic          WFIFO_REN;
    logic [31:0]   WFIFO_RDATA;
    logic          WFIFO_REMPTY;
    logic          RFIFO_WEN;
    logic [31:0]   RFIFO_WDATA;
    logic          RFIFO_WFULL;
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-3:0] MEM_ADDR;
    logic [3:0]    MEM_BE;
    logic [31:0]   MEM_WDATA;
    logic          MEM_ACK;
    logic          MEM_RVALID;
    logic [31:0]   MEM_RDATA;

    logic [35:0] cmdQ[$];
    logic [31:0] wdQ[$];
    logic [31:0] rdDataQ[$];
    memTxn_t     expMemQ[$];
    logic [31:0] expRdQ[$];

    int          errCount = 0;
    int          checkCount = 0;
    int          cyc = 0;
    int          ackDelay = 2;
    int          rvDelay = 3;
    bit          rfifoFull = 1'b0;
    int          reqAge = 0;
    int          rvCount = 0;
    bit          rvPending = 1'b0;
    logic [31:0] rvData = 32'h0;
    int          cPops = 0, wPops = 0, expCPops = 0, expWPops = 0;
    bit          busy = 1'b0;
    int          cpopCycle = -10, wpopCycle = -10;
    int          ackCount = 0;
    bit          prevReq = 1'b0;
    memTxn_t     prevSnap = '0;

    sdram_fifo_cmd_exec #(.ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CFIFO_REN    (CFIFO_REN),
        .CFIFO_RDATA  (CFIFO_RDATA),
        .CFIFO_REMPTY (CFIFO_REMPTY),
        .WFIFO_REN    (WFIFO_REN),
        .WFIFO_RDATA  (WFIFO_RDATA),
        .WFIFO_REMPTY (WFIFO_REMPTY),
        .RFIFO_WEN    (RFIFO_WEN),
        .RFIFO_WDATA  (RFIFO_WDATA),
        .RFIFO_WFULL  (RFIFO_WFULL),
        .MEM_REQ      (MEM_REQ),
        .MEM_WE       (MEM_WE),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_BE       (MEM_BE),
        .MEM_WDATA    (MEM_WDATA),
        .MEM_ACK      (MEM_ACK),
        .MEM_RVALID   (MEM_RVALID),
        .MEM_RDATA    (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // FIFO and SDRAM-core models: pop on the edge, drive new values 1 ns later.
    always @(posedge CLK) begin
        cyc++;
        if (CFIFO_REN === 1'b1 && cmdQ.size() > 0) void'(cmdQ.pop_front());
        if (WFIFO_REN === 1'b1 && wdQ.size() > 0) void'(wdQ.pop_front());
        #1;
        CFIFO_REMPTY = (cmdQ.size() == 0);
        CFIFO_RDATA  = CFIFO_REMPTY ? 36'h0 : cmdQ[0];
        WFIFO_REMPTY = (wdQ.size() == 0);
        WFIFO_RDATA  = WFIFO_REMPTY ? 32'h0 : wdQ[0];
        RFIFO_WFULL  = rfifoFull;
        MEM_ACK      = 1'b0;
        MEM_RVALID   = 1'b0;
        if (MEM_REQ === 1'b1) begin
            if (reqAge >= ackDelay) begin
                MEM_ACK = 1'b1;
                reqAge  = 0;
                if (MEM_WE === 1'b0) begin
                    rvPending = 1'b1;
                    rvCount   = rvDelay;
                    rvData    = 32'hBAD0BAD0;
                    if (rdDataQ.size() > 0) rvData = rdDataQ.pop_front();
                end
            end else begin
                reqAge++;
            end
        end else begin
            reqAge = 0;
        end
        if (rvPending) begin
            if (rvCount == 0) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = rvData;
                rvPending  = 1'b0;
            end else begin
                rvCount--;
            end
        end
    end

    // Monitor: ordering, latency, stability and scoreboard comparisons.
    always @(negedge CLK) begin
        if (CFIFO_REN === 1'b1) begin
            checkOutput("cfifo_pop_while_busy", {63'h0, busy}, 64'h0);
            busy = 1'b1;
            cPops++;
            cpopCycle = cyc;
        end
        if (MEM_REQ === 1'b1 && !prevReq) begin
            if (MEM_WE === 1'b1) checkOutput("write_req_latency", cyc, wpopCycle + 1);
            else                 checkOutput("read_req_latency", cyc, cpopCycle + 1);
        end
        if (MEM_REQ === 1'b1 && prevReq) begin
            checkOutput("req_fields_stable", {MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA}, prevSnap);
        end
        prevReq  = (MEM_REQ === 1'b1);
        prevSnap = {MEM_WE, MEM_ADDR, MEM_BE, MEM_WDATA};
        if (MEM_REQ === 1'b1 && MEM_ACK) begin
            memTxn_t e;
            ackCount++;
            if (expMemQ.size() == 0) begin
                checkOutput("unexpected_mem_req", MEM_REQ, 0);
            end else begin
                e = expMemQ.pop_front();
                checkOutput("mem_we", MEM_WE, e.we);
                checkOutput("mem_addr", MEM_ADDR, e.addr);
                checkOutput("mem_be", MEM_BE, e.be);
                if (e.we) checkOutput("mem_wdata", MEM_WDATA, e.wdata);
            end
            if (MEM_WE === 1'b1) busy = 1'b0;
        end
        if (RFIFO_WEN === 1'b1) begin
            checkOutput("rfifo_wen_while_full", RFIFO_WFULL, 0);
            if (expRdQ.size() == 0) checkOutput("unexpected_rfifo_push", RFIFO_WEN, 0);
            else                    checkOutput("rfifo_wdata", RFIFO_WDATA, expRdQ.pop_front());
            busy = 1'b0;
        end
        if (WFIFO_REN === 1'b1) begin
            wPops++;
            wpopCycle = cyc;
        end
        if (RST === 1'b1) begin
            busy    = 1'b0;
            prevReq = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Queue one command with its hand-computed expected memory request.
    task automatic applyStimulus(input logic [35:0] cmd, input logic expWe, input logic [AW-3:0] expAddr,
                                 input logic [3:0] expBe, input logic [31:0] data,
                                 input bit pushWdata, input bit expectRead);
        cmdQ.push_back(cmd);
        expCPops++;
        expMemQ.push_back({expWe, expAddr, expBe, expWe ? data : 32'h0});
        if (expWe && pushWdata) begin
            wdQ.push_back(data);
            expWPops++;
        end
        if (!expWe) begin
            rdDataQ.push_back(data);
            if (expectRead) expRdQ.push_back(data);
        end
    endtask

    task automatic waitDone(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmdQ.size() == 0 && wdQ.size() == 0 && expMemQ.size() == 0 &&
                expRdQ.size() == 0 && !busy && !rvPending) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("drain_timeout", {63'h0, done}, 64'h1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_mem_req", MEM_REQ, 0);
        checkOutput("rst_mem_we", MEM_WE, 0);
        checkOutput("rst_mem_addr", MEM_ADDR, 0);
        checkOutput("rst_mem_be", MEM_BE, 0);
        checkOutput("rst_mem_wdata", MEM_WDATA, 0);
        checkOutput("rst_rfifo_wdata", RFIFO_WDATA, 0);
        checkOutput("rst_rfifo_wen", RFIFO_WEN, 0);
        checkOutput("rst_cfifo_ren", CFIFO_REN, 0);
        checkOutput("rst_wfifo_ren", WFIFO_REN, 0);
    endtask

    initial begin
        int startAck;
        RST          = 1'b1;
        CFIFO_REMPTY = 1'b1;
        CFIFO_RDATA  = '0;
        WFIFO_REMPTY = 1'b1;
        WFIFO_RDATA  = '0;
        RFIFO_WFULL  = 1'b0;
        MEM_ACK      = 1'b0;
        MEM_RVALID   = 1'b0;
        MEM_RDATA    = '0;
        repeat (3) tick();
        checkResetOutputs();
        RST = 1'b0;
        tick();

        ackDelay = 2;
        applyStimulus(36'hA_0000_0104, 1'b1, 24'h000041, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0);
        waitDone(50);
        checkOutput("word_write_cfifo_pops", cPops, 1);
        checkOutput("word_write_wfifo_pops", wPops, 1);

        ackDelay = 0;
        applyStimulus(36'h8_0000_0003, 1'b1, 24'h000000, 4'h8, 32'h11000000, 1'b1, 1'b0);
        applyStimulus(36'h9_0000_0002, 1'b1, 24'h000000, 4'hC, 32'h22220000, 1'b1, 1'b0);
        applyStimulus(36'h8_0000_0000, 1'b1, 24'h000000, 4'h1, 32'h00000033, 1'b1, 1'b0);
        waitDone(80);

        rvDelay = 0;
        applyStimulus(36'h2_FC00_0008, 1'b0, 24'h000002, 4'hF, 32'h0F1E2D3C, 1'b0, 1'b1);
        waitDone(50);

        ackDelay  = 2;
        rvDelay   = 3;
        rfifoFull = 1'b1;
        startAck  = ackCount;
        applyStimulus(36'h2_0000_0010, 1'b0, 24'h000004, 4'hF, 32'h12345678, 1'b0, 1'b1);
        for (int i = 0; i < 30 && ackCount == startAck; i++) tick();
        checkOutput("bp_ack_seen", ackCount, startAck + 1);
        repeat (8) begin
            tick();
            checkOutput("bp_no_push_while_full", RFIFO_WEN, 0);
        end
        rfifoFull = 1'b0;
        waitDone(50);

        applyStimulus(36'h8_0000_0005, 1'b1, 24'h000001, 4'h2, 32'h0000AB00, 1'b0, 1'b0);
        repeat (5) begin
            tick();
            checkOutput("starved_no_req", MEM_REQ, 0);
        end
        wdQ.push_back(32'h0000AB00);
        expWPops++;
        waitDone(50);

        rvDelay = 1;
        applyStimulus(36'h1_0000_0022, 1'b0, 24'h000008, 4'hC, 32'hA5A50001, 1'b0, 1'b1);
        applyStimulus(36'h9_0000_0030, 1'b1, 24'h00000C, 4'h3, 32'hCAFEF00D, 1'b1, 1'b0);
        waitDone(80);

        rvDelay  = 2;
        startAck = ackCount;
        applyStimulus(36'h2_0000_0040, 1'b0, 24'h000010, 4'hF, 32'h55AA55AA, 1'b0, 1'b0);
        for (int i = 0; i < 30 && ackCount == startAck; i++) tick();
        checkOutput("rst_test_ack_seen", ackCount, startAck + 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkResetOutputs();
        repeat (8) begin
            tick();
            checkOutput("post_rst_no_req", MEM_REQ, 0);
            checkOutput("post_rst_no_push", RFIFO_WEN, 0);
        end

        rvDelay = 1;
        applyStimulus(36'h2_0000_0080, 1'b0, 24'h000020, 4'hF, 32'h0BADF00D, 1'b0, 1'b1);
        waitDone(50);

        checkOutput("total_cfifo_pops", cPops, expCPops);
        checkOutput("total_wfifo_pops", wPops, expWPops);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
